// File: rtl/secded_serial_rx.sv
// secded_serial_rx
//   Receive end of the SECDED serial link. Bits of an 8-bit codeword arrive
//   one per qualified cycle, bit0 first. Codeword layout: Hamming(7,4) in bits 6..0
//   (positions 1..7 = p1,p2,d1,p3,d2,d3,d4), overall even parity in bit7.
//   After the last bit, one DECODE cycle classifies and corrects the word. The
//   result is then loaded into a single-entry output register that has a
//   valid/ready handshake. Saturating counters track errors and dropped words.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   i_sframe          frame envelope, high for the whole codeword
//   i_sbit_vld        qualifies i_sdata
//   i_sdata           serial codeword bit
//   o_data            corrected data {d4,d3,d2,d1}
//   o_syndrome        Hamming syndrome of the received word
//   o_1bit_err        single error, corrected
//   o_2bit_err        double error, data passed through uncorrected
//   o_par_err         only the overall parity bit was wrong
//   o_valid, i_ready  output handshake
//   o_frame_err       pulse: frame ended before 8 bits
//   o_overflow        pulse: decoded word dropped because the output was full
//   i_clr_cnt         synchronous clear of all counters
//   o_cnt_1bit/2bit/drop  saturating statistics
module secded_serial_rx #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sframe,
  input  logic             i_sbit_vld,
  input  logic             i_sdata,
  output logic [3:0]       o_data,
  output logic [2:0]       o_syndrome,
  output logic             o_1bit_err,
  output logic             o_2bit_err,
  output logic             o_par_err,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_frame_err,
  output logic             o_overflow,
  input  logic             i_clr_cnt,
  output logic [CNT_W-1:0] o_cnt_1bit,
  output logic [CNT_W-1:0] o_cnt_2bit,
  output logic [CNT_W-1:0] o_cnt_drop
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DECODE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  word_q, word_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        need_low_q, need_low_d;

  logic        start_ok;
  logic        cap_first, cap_bit, abort_w, load_w, last_bit;

  logic [2:0]  syn;
  logic        pm, err_sgl, err_dbl, err_par;
  logic [3:0]  data_fix;

  logic        accept, ovf_d, do_load;
  logic [3:0]  data_q;
  logic [2:0]  syn_q;
  logic        e1_q, e2_q, ep_q, valid_q, ferr_q, ovf_q;
  logic [CNT_W-1:0] cnt_q [3];
  logic [2:0]  cnt_inc;

  // A frame may only start once i_sframe has been seen low after the previous
  // frame's bit7, so an envelope held high past bit7 cannot alias a new frame.
  assign start_ok = i_sframe & i_sbit_vld & ~need_low_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (!i_sframe)                              state_d = ST_IDLE;
        else if (i_sbit_vld && bitcnt_q == 3'd7)    state_d = ST_DECODE;
      end
      ST_DECODE: state_d = start_ok ? ST_SHIFT : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (control strobes) ----------------
  always_comb begin
    cap_first = 1'b0;
    cap_bit   = 1'b0;
    abort_w   = 1'b0;
    load_w    = 1'b0;
    case (state_q)
      ST_IDLE:   cap_first = start_ok;
      ST_SHIFT: begin
        abort_w = ~i_sframe;
        cap_bit = i_sframe & i_sbit_vld;
      end
      ST_DECODE: begin
        load_w    = 1'b1;
        cap_first = start_ok;
      end
      default: ;
    endcase
  end

  assign last_bit = cap_bit & (bitcnt_q == 3'd7);

  // ---------------- deserialiser ----------------
  always_comb begin
    word_d     = word_q;
    bitcnt_d   = bitcnt_q;
    need_low_d = need_low_q;
    if (cap_first) begin
      word_d[0] = i_sdata;
      bitcnt_d  = 3'd1;
    end else if (cap_bit) begin
      word_d[bitcnt_q] = i_sdata;
      bitcnt_d         = bitcnt_q + 3'd1;   // wraps to 0 after bit7
    end else if (abort_w) begin
      bitcnt_d = 3'd0;
    end
    if (!i_sframe) need_low_d = 1'b0;
    if (last_bit)  need_low_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      bitcnt_q   <= '0;
      need_low_q <= 1'b0;
    end else begin
      word_q     <= word_d;
      bitcnt_q   <= bitcnt_d;
      need_low_q <= need_low_d;
    end
  end

  // ---------------- decoder (valid during DECODE) ----------------
  assign syn[0]  = word_q[0] ^ word_q[2] ^ word_q[4] ^ word_q[6];
  assign syn[1]  = word_q[1] ^ word_q[2] ^ word_q[5] ^ word_q[6];
  assign syn[2]  = word_q[3] ^ word_q[4] ^ word_q[5] ^ word_q[6];
  assign pm      = ^word_q;
  assign err_sgl = (syn != 3'd0) &  pm;
  assign err_dbl = (syn != 3'd0) & ~pm;
  assign err_par = (syn == 3'd0) &  pm;

  // Data bits sit at Hamming positions 3,5,6,7; each is flipped only when a
  // single error points exactly at it.
  for (genvar gi = 0; gi < 4; gi++) begin : g_fix
    localparam int POS = (gi == 0) ? 3 : (gi == 1) ? 5 : (gi == 2) ? 6 : 7;
    assign data_fix[gi] = word_q[POS-1] ^ (err_sgl & (syn == 3'(POS)));
  end

  // ---------------- output register / handshake ----------------
  assign accept  = valid_q & i_ready;
  assign ovf_d   = load_w & valid_q & ~i_ready;
  assign do_load = load_w & ~ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      syn_q   <= '0;
      e1_q    <= 1'b0;
      e2_q    <= 1'b0;
      ep_q    <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_load) begin
        data_q  <= data_fix;
        syn_q   <= syn;
        e1_q    <= err_sgl;
        e2_q    <= err_dbl;
        ep_q    <= err_par;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
      ferr_q <= abort_w;
      ovf_q  <= ovf_d;
    end
  end

  // ---------------- saturating counters: [0]=1bit [1]=2bit [2]=drop ----------------
  assign cnt_inc = {abort_w | ovf_d, do_load & err_dbl, do_load & err_sgl};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (i_clr_cnt)                            cnt_q[i] <= '0;
        else if (cnt_inc[i] && cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + CNT_ONE;
      end
    end
  end

  assign o_data      = data_q;
  assign o_syndrome  = syn_q;
  assign o_1bit_err  = e1_q;
  assign o_2bit_err  = e2_q;
  assign o_par_err   = ep_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overflow  = ovf_q;
  assign o_cnt_1bit  = cnt_q[0];
  assign o_cnt_2bit  = cnt_q[1];
  assign o_cnt_drop  = cnt_q[2];

endmodule

// File: tb/tb_secded_serial_rx.sv
// Testbench for secded_serial_rx. A driver sends codewords (clean or with
// injected bit flips) and pushes the expected outcome, tagged with the clock edge
// it should take effect on, into a queue. A monitor replays the output-register
// and counter rules at transaction level and compares every cycle.
module tb_secded_serial_rx;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst_n = 1'b1;
  logic i_sframe = 1'b0, i_sbit_vld = 1'b0, i_sdata = 1'b0;
  logic i_ready = 1'b0, i_clr_cnt = 1'b0;
  logic [3:0] o_data;
  logic [2:0] o_syndrome;
  logic o_1bit_err, o_2bit_err, o_par_err, o_valid, o_frame_err, o_overflow;
  logic [CNT_W-1:0] o_cnt_1bit, o_cnt_2bit, o_cnt_drop;

  secded_serial_rx #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_sframe(i_sframe), .i_sbit_vld(i_sbit_vld),
    .i_sdata(i_sdata), .o_data(o_data), .o_syndrome(o_syndrome),
    .o_1bit_err(o_1bit_err), .o_2bit_err(o_2bit_err), .o_par_err(o_par_err),
    .o_valid(o_valid), .i_ready(i_ready), .o_frame_err(o_frame_err),
    .o_overflow(o_overflow), .i_clr_cnt(i_clr_cnt), .o_cnt_1bit(o_cnt_1bit),
    .o_cnt_2bit(o_cnt_2bit), .o_cnt_drop(o_cnt_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         edge_n;
    bit         is_abort;
    logic [7:0] w;
    logic [3:0] d;
    logic [2:0] s;
    bit         e1, e2, ep;
  } ev_t;

  ev_t ev_q[$];
  int  checks = 0, errors = 0;
  bit  rand_ready = 0, rand_clr = 0, ready_fix = 0, pulse_on_load = 0;
  int  ready_pulse_edge = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[7] = ^c[6:0];
    return c;
  endfunction

  // Expected outcome derived from which bits were flipped, not from the syndrome equations.
  function automatic ev_t expect_word(input logic [3:0] d, input int nflip, input int pa, input int pb);
    ev_t e;
    logic [7:0] w;
    e = '{default: 0};
    w = encode(d);
    if (nflip >= 1) w[pa] = ~w[pa];
    if (nflip == 2) w[pb] = ~w[pb];
    e.w = w;
    e.d = d;
    if (nflip == 1) begin
      if (pa == 7) e.ep = 1;
      else begin e.e1 = 1; e.s = 3'(pa + 1); end
    end else if (nflip == 2) begin
      e.e2 = 1;
      if (pa == 7)      e.s = 3'(pb + 1);
      else if (pb == 7) e.s = 3'(pa + 1);
      else              e.s = 3'((pa + 1) ^ (pb + 1));
      e.d = {w[6], w[5], w[4], w[2]};
    end
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rand_ready) i_ready = ($urandom_range(0, 1) == 1);
    else            i_ready = ready_fix || (cyc + 1 == ready_pulse_edge);
    i_clr_cnt = rand_clr && ($urandom_range(0, 299) == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      i_sframe = 0; i_sbit_vld = $urandom_range(0, 1); i_sdata = $urandom_range(0, 1);
    end
  endtask

  // abort_after in 1..7 drops i_sframe after that many bits; 8 sends the full word.
  task automatic send_frame(input ev_t e, input int abort_after);
    idle($urandom_range(1, 3));
    for (int b = 0; b < 8; b++) begin
      if (b == abort_after) begin
        tick();
        i_sframe = 0; i_sbit_vld = $urandom_range(0, 1); i_sdata = $urandom_range(0, 1);
        e.is_abort = 1; e.edge_n = cyc + 1;
        ev_q.push_back(e);
        return;
      end
      while ($urandom_range(0, 3) == 0) begin
        tick();
        i_sframe = 1; i_sbit_vld = 0; i_sdata = $urandom_range(0, 1);
      end
      tick();
      i_sframe = 1; i_sbit_vld = 1; i_sdata = e.w[b];
      if (b == 7) begin
        e.is_abort = 0; e.edge_n = cyc + 2;
        if (pulse_on_load) ready_pulse_edge = cyc + 2;
        ev_q.push_back(e);
      end
    end
    // Envelope held high past bit7 with more qualified bits: must be ignored.
    if ($urandom_range(0, 3) == 0) begin
      repeat (2) begin
        tick();
        i_sframe = 1; i_sbit_vld = 1; i_sdata = $urandom_range(0, 1);
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    ev_t e, le, mw;
    bit  rdy, clr, hl, ha, mv, fx, ox;
    int  c1, c2, cd;
    mv = 0; mw = '{default: 0}; c1 = 0; c2 = 0; cd = 0;
    forever begin
      @(posedge clk);
      rdy = i_ready; clr = i_clr_cnt;
      #1;
      fx = 0; ox = 0;
      if (!rst_n) begin
        mv = 0; mw = '{default: 0}; c1 = 0; c2 = 0; cd = 0;
        ev_q.delete();
      end else begin
        hl = 0; ha = 0; le = '{default: 0};
        while (ev_q.size() > 0 && ev_q[0].edge_n <= cyc) begin
          e = ev_q.pop_front();
          if (e.is_abort) ha = 1;
          else begin hl = 1; le = e; end
        end
        if (hl) begin
          if (mv && !rdy) begin
            ox = 1;
            if (!clr && cd < CMAX) cd++;
            $display("edge %0d overflow drop w=%h", cyc, le.w);
          end else begin
            if (mv) $display("edge %0d accept d=%h s=%0d", cyc, mw.d, mw.s);
            mw = le; mv = 1;
            if (!clr && le.e1 && c1 < CMAX) c1++;
            if (!clr && le.e2 && c2 < CMAX) c2++;
          end
        end else if (mv && rdy) begin
          $display("edge %0d accept d=%h s=%0d e1=%0b e2=%0b ep=%0b", cyc, mw.d, mw.s, mw.e1, mw.e2, mw.ep);
          mv = 0;
        end
        if (ha) begin
          fx = 1;
          if (!clr && cd < CMAX) cd++;
          $display("edge %0d frame abort", cyc);
        end
        if (clr) begin c1 = 0; c2 = 0; cd = 0; end
      end
      chk("o_valid", 32'(o_valid), 32'(mv));
      chk("o_data", 32'(o_data), 32'(mw.d));
      chk("o_syndrome", 32'(o_syndrome), 32'(mw.s));
      chk("o_1bit_err", 32'(o_1bit_err), 32'(mw.e1));
      chk("o_2bit_err", 32'(o_2bit_err), 32'(mw.e2));
      chk("o_par_err", 32'(o_par_err), 32'(mw.ep));
      chk("o_frame_err", 32'(o_frame_err), 32'(fx));
      chk("o_overflow", 32'(o_overflow), 32'(ox));
      chk("o_cnt_1bit", 32'(o_cnt_1bit), 32'(c1));
      chk("o_cnt_2bit", 32'(o_cnt_2bit), 32'(c2));
      chk("o_cnt_drop", 32'(o_cnt_drop), 32'(cd));
    end
  end

  // ---------------- stimulus ----------------
  initial begin : driver
    ev_t e;
    int  nf, pa, pb;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    idle(2);
    ready_fix = 1;

    send_frame(expect_word(4'hB, 0, 0, 0), 8);  // 8'h55 clean
    send_frame(expect_word(4'hB, 1, 4, 0), 8);  // 8'h45 single, s=5
    send_frame(expect_word(4'hB, 1, 7, 0), 8);  // 8'hD5 parity only
    send_frame(expect_word(4'hB, 2, 0, 1), 8);  // 8'h56 double
    send_frame(expect_word(4'h3, 0, 0, 0), 5);  // aborted after 5 bits
    idle(4);

    // Reset in the middle of a frame, then a clean frame.
    e = expect_word(4'hB, 0, 0, 0);
    for (int b = 0; b < 4; b++) begin
      tick();
      i_sframe = 1; i_sbit_vld = 1; i_sdata = e.w[b];
    end
    tick();
    rst_n = 0; i_sframe = 0; i_sbit_vld = 0;
    idle(2);
    rst_n = 1;
    send_frame(e, 8);
    idle(4);

    // Overflow: consumer stalled, two words back to back.
    ready_fix = 0;
    send_frame(expect_word(4'hB, 0, 0, 0), 8);
    send_frame(expect_word(4'hB, 1, 4, 0), 8);
    idle(3);
    ready_fix = 1; idle(3); ready_fix = 0;
    // Accept on the same edge as the new load: no overflow.
    send_frame(expect_word(4'hB, 0, 0, 0), 8);
    pulse_on_load = 1;
    send_frame(expect_word(4'hB, 1, 4, 0), 8);
    pulse_on_load = 0;
    idle(3);
    ready_fix = 1; idle(3);

    // Saturation of the single-error counter, then clear.
    repeat (CMAX + 2) send_frame(expect_word(4'($urandom_range(0, 15)), 1, $urandom_range(0, 6), 0), 8);
    idle(4);
    tick(); i_clr_cnt = 1;
    idle(3);

    // Randomised traffic.
    rand_ready = 1; rand_clr = 1;
    repeat (300) begin
      nf = $urandom_range(0, 2);
      pa = $urandom_range(0, 7);
      pb = (pa + $urandom_range(1, 7)) % 8;
      send_frame(expect_word(4'($urandom_range(0, 15)), nf, pa, pb),
                 ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 8);
    end
    rand_ready = 0; rand_clr = 0; ready_fix = 1;
    idle(10);
    chk("pending_events", 32'(ev_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
